// File: rtl/ex_muldiv_ctrl_pkg.sv
// Shared definitions for the RV32M multiply/divide controller: operand width,
// iteration count, funct3 op encodings, FSM state encoding and shortcut codes.
package ex_muldiv_ctrl_pkg;

    localparam int XLEN     = 32;
    localparam int ITER_CNT = 32;
    localparam int CNT_W    = 5;

    typedef enum logic [2:0] {
        OP_MUL    = 3'd0,
        OP_MULH   = 3'd1,
        OP_MULHSU = 3'd2,
        OP_MULHU  = 3'd3,
        OP_DIV    = 3'd4,
        OP_DIVU   = 3'd5,
        OP_REM    = 3'd6,
        OP_REMU   = 3'd7
    } op_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CALC = 2'd1,
        ST_FIX  = 2'd2,
        ST_DONE = 2'd3
    } state_e;

    // Operations that bypass the iterative loop and get a fixed answer in FIX.
    typedef enum logic [1:0] {
        SP_NONE = 2'd0,
        SP_DIVZ = 2'd1,
        SP_OVF  = 2'd2,
        SP_ZERO = 2'd3
    } special_e;

endpackage

// File: rtl/muldiv_addsub.sv
// 33-bit adder/subtractor with carry-out; one iteration step of shift-add
// multiply or restoring divide. With sub=1 the carry-out means a >= b.
module muldiv_addsub (
    input  logic [32:0] a,
    input  logic [32:0] b,
    input  logic        sub,
    output logic [32:0] sum,
    output logic        cout
);

    // Two's-complement subtract as a + ~b + 1.
    always_comb begin
        {cout, sum} = {1'b0, a} + {1'b0, (sub ? ~b : b)} + {33'b0, sub};
    end

endmodule

// File: rtl/ex_muldiv_ctrl.sv
// RV32M multiply/divide controller: 32-iteration shift-add multiply and
// restoring divide on operand magnitudes, sign fix-up in FIX, result in DONE.
// Optional build macro MULDIV_EARLY_OUT_EN: multiplies with a zero operand
// skip the loop and finish two cycles after start.
// Handshake: start is sampled only in IDLE; busy is high in CALC and FIX;
// done pulses for one cycle in DONE with result valid, result holds until the
// next done. flush aborts in any state and wins over start.
module ex_muldiv_ctrl
    import ex_muldiv_ctrl_pkg::*;
(
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic [2:0]      op,
    input  logic [XLEN-1:0] srcop1,
    input  logic [XLEN-1:0] srcop2,
    input  logic            flush,
    output logic            busy,
    output logic            done,
    output logic [XLEN-1:0] result,
    output state_e          dbg_state
);

    state_e          state, state_nxt;
    logic [CNT_W-1:0] cnt;
    logic [XLEN-1:0] hi, lo, mag2, src1_q;
    logic [2:0]      op_q;
    logic            neg_q;
    special_e        special_q, special_in;

    logic            s1, s2, neg_in, early_zero;
    logic [XLEN-1:0] mag1_in, mag2_in;
    logic [32:0]     as_a, as_b, as_sum;
    logic            as_cout;
    logic [63:0]     prod_fix;
    logic [XLEN-1:0] div_sel, fix_val;

    assign dbg_state = state;
    assign busy      = (state == ST_CALC) || (state == ST_FIX);
    assign done      = (state == ST_DONE) && !flush;

    // Operand classification at start: signs, magnitudes, shortcut cases.
    always_comb begin
        s1 = srcop1[31] && (op == OP_MULH || op == OP_MULHSU || op == OP_DIV || op == OP_REM);
        s2 = srcop2[31] && (op == OP_MULH || op == OP_DIV || op == OP_REM);
        neg_in  = (op == OP_REM) ? s1 : (s1 ^ s2);
        mag1_in = s1 ? (~srcop1 + 32'd1) : srcop1;
        mag2_in = s2 ? (~srcop2 + 32'd1) : srcop2;
`ifdef MULDIV_EARLY_OUT_EN
        early_zero = !op[2] && (srcop1 == '0 || srcop2 == '0);
`else
        early_zero = 1'b0;
`endif
        special_in = SP_NONE;
        if (op[2] && srcop2 == '0)
            special_in = SP_DIVZ;
        else if ((op == OP_DIV || op == OP_REM) && srcop1 == 32'h8000_0000 && srcop2 == 32'hFFFF_FFFF)
            special_in = SP_OVF;
        else if (early_zero)
            special_in = SP_ZERO;
    end

    // State register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= ST_IDLE;
        else      state <= state_nxt;
    end

    // Next-state logic; flush returns to IDLE from anywhere.
    always_comb begin
        state_nxt = state;
        if (flush) begin
            state_nxt = ST_IDLE;
        end else begin
            case (state)
                ST_IDLE: if (start) state_nxt = (special_in != SP_NONE) ? ST_FIX : ST_CALC;
                ST_CALC: if (cnt == '0) state_nxt = ST_FIX;
                ST_FIX:  state_nxt = ST_DONE;
                ST_DONE: state_nxt = ST_IDLE;
                default: state_nxt = ST_IDLE;
            endcase
        end
    end

    // Iteration step operands: multiply adds the multiplicand when the current
    // multiplier bit is set; divide trial-subtracts the divisor.
    always_comb begin
        if (op_q[2]) begin
            as_a = {hi, lo[31]};
            as_b = {1'b0, mag2};
        end else begin
            as_a = {1'b0, hi};
            as_b = {1'b0, (lo[0] ? mag2 : 32'd0)};
        end
    end

    muldiv_addsub u_addsub (
        .a    (as_a),
        .b    (as_b),
        .sub  (op_q[2]),
        .sum  (as_sum),
        .cout (as_cout)
    );

    // Sign correction and word selection applied in FIX.
    always_comb begin
        prod_fix = neg_q ? (~{hi, lo} + 64'd1) : {hi, lo};
        div_sel  = op_q[1] ? hi : lo;
        fix_val  = '0;
        case (special_q)
            SP_DIVZ: fix_val = op_q[1] ? src1_q : 32'hFFFF_FFFF;
            SP_OVF:  fix_val = op_q[1] ? 32'd0 : 32'h8000_0000;
            SP_ZERO: fix_val = 32'd0;
            default: begin
                if (op_q[2])
                    fix_val = neg_q ? (~div_sel + 32'd1) : div_sel;
                else
                    fix_val = (op_q[1:0] == 2'b00) ? prod_fix[31:0] : prod_fix[63:32];
            end
        endcase
    end

    // Datapath: latch at start, iterate in CALC, load result leaving FIX.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt       <= '0;
            hi        <= '0;
            lo        <= '0;
            mag2      <= '0;
            src1_q    <= '0;
            op_q      <= '0;
            neg_q     <= 1'b0;
            special_q <= SP_NONE;
            result    <= '0;
        end else begin
            if (state == ST_IDLE && start && !flush) begin
                op_q      <= op;
                src1_q    <= srcop1;
                hi        <= '0;
                lo        <= mag1_in;
                mag2      <= mag2_in;
                neg_q     <= neg_in;
                special_q <= special_in;
                cnt       <= CNT_W'(ITER_CNT - 1);
            end else if (state == ST_CALC) begin
                if (op_q[2]) begin
                    hi <= as_cout ? as_sum[31:0] : as_a[31:0];
                    lo <= {lo[30:0], as_cout};
                end else begin
                    hi <= as_sum[32:1];
                    lo <= {as_sum[0], lo[31:1]};
                end
                if (cnt != '0) cnt <= cnt - 1'b1;
            end else if (state == ST_FIX && !flush) begin
                result <= fix_val;
            end
        end
    end

endmodule

// File: tb/tb_ex_muldiv_ctrl.sv
// Self-checking bench for ex_muldiv_ctrl: directed cases then random
// operations checked against an arithmetic reference model.
module tb_ex_muldiv_ctrl;
    import ex_muldiv_ctrl_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        start = 1'b0;
    logic [2:0]  op = 3'd0;
    logic [31:0] srcop1 = '0;
    logic [31:0] srcop2 = '0;
    logic        flush = 1'b0;
    logic        busy, done;
    logic [31:0] result;
    state_e      dbg_state;

    int vectors = 0;
    int miscompares = 0;
    logic [31:0] last_result = '0;
    logic [31:0] exp_q[$];

    always #5 clk = ~clk;

    ex_muldiv_ctrl dut (
        .clk(clk), .rst(rst), .start(start), .op(op), .srcop1(srcop1),
        .srcop2(srcop2), .flush(flush), .busy(busy), .done(done),
        .result(result), .dbg_state(dbg_state)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        assert (got === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] ref_result(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
        longint sa, sb, ua, ub;
        logic [63:0] p;
        logic ovf;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ua = longint'({32'd0, a});
        ub = longint'({32'd0, b});
        ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
        p = '0;
        case (o)
            3'd0: begin p = ua * ub; return p[31:0]; end
            3'd1: begin p = sa * sb; return p[63:32]; end
            3'd2: begin p = sa * ub; return p[63:32]; end
            3'd3: begin p = ua * ub; return p[63:32]; end
            3'd4: begin
                if (b == 0) return 32'hFFFF_FFFF;
                if (ovf) return 32'h8000_0000;
                p = sa / sb; return p[31:0];
            end
            3'd5: begin
                if (b == 0) return 32'hFFFF_FFFF;
                return a / b;
            end
            3'd6: begin
                if (b == 0) return a;
                if (ovf) return 32'd0;
                p = sa % sb; return p[31:0];
            end
            default: begin
                if (b == 0) return a;
                return a % b;
            end
        endcase
    endfunction

    function automatic int ref_latency(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
        if (o >= 3'd4 && b == 0) return 2;
        if ((o == 3'd4 || o == 3'd6) && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 2;
`ifdef MULDIV_EARLY_OUT_EN
        if (o < 3'd4 && (a == 0 || b == 0)) return 2;
`endif
        return 34;
    endfunction

    // One operation; with noise, start/op/operands wiggle while it is busy.
    task automatic run_op(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b, input bit noise);
        int lat;
        logic [31:0] exp;
        exp_q.push_back(ref_result(o, a, b));
        lat = ref_latency(o, a, b);
        @(negedge clk);
        start = 1'b1; op = o; srcop1 = a; srcop2 = b;
        for (int c = 1; c <= lat + 1; c++) begin
            @(negedge clk);
            chk($sformatf("busy op%0d c%0d", o, c), {31'd0, busy}, {31'd0, (c < lat)});
            chk($sformatf("done op%0d c%0d", o, c), {31'd0, done}, {31'd0, (c == lat)});
            if (c < lat) chk($sformatf("hold op%0d c%0d", o, c), result, last_result);
            if (c == lat) begin
                exp = exp_q.pop_front();
                chk($sformatf("result op%0d %h,%h", o, a, b), result, exp);
                last_result = exp;
            end
            if (noise && c <= lat) begin
                start = 1'($urandom_range(0, 1));
                op = 3'($urandom_range(0, 7));
                srcop1 = $urandom;
                srcop2 = $urandom;
            end else begin
                start = 1'b0;
            end
        end
        start = 1'b0;
    endtask

    function automatic logic [31:0] pick_operand();
        case ($urandom_range(0, 9))
            0: return 32'd0;
            1: return 32'hFFFF_FFFF;
            2: return 32'h8000_0000;
            3: return 32'($urandom_range(1, 20));
            default: return $urandom;
        endcase
    endfunction

    initial begin
        bit seen;
        // Reset state
        #2;
        chk("reset busy", {31'd0, busy}, 32'd0);
        chk("reset done", {31'd0, done}, 32'd0);
        chk("reset result", result, 32'd0);
        @(negedge clk);
        rst = 1'b1;

        // Directed cases
        run_op(3'd0, 32'd7, 32'd6, 1'b0);
        run_op(3'd4, 32'hFFFF_FFEC, 32'd3, 1'b0);
        run_op(3'd6, 32'hFFFF_FFEC, 32'd3, 1'b0);
        run_op(3'd5, 32'd100, 32'd0, 1'b0);
        run_op(3'd7, 32'd100, 32'd0, 1'b0);
        run_op(3'd1, 32'h8000_0000, 32'h8000_0000, 1'b0);
        run_op(3'd3, 32'hFFFF_FFFF, 32'd2, 1'b0);
        run_op(3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
        run_op(3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
        run_op(3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
        run_op(3'd0, 32'd0, 32'd5, 1'b0);

        // Flush at cycle 10 of a MUL with start asserted in the same cycle
        @(negedge clk);
        start = 1'b1; op = 3'd0; srcop1 = 32'd9; srcop2 = 32'd9;
        @(negedge clk);
        start = 1'b0;
        for (int c = 1; c < 10; c++) @(negedge clk);
        flush = 1'b1; start = 1'b1; op = 3'd0; srcop1 = 32'd3; srcop2 = 32'd3;
        @(negedge clk);
        flush = 1'b0; start = 1'b0;
        chk("flush busy c11", {31'd0, busy}, 32'd0);
        chk("flush done c11", {31'd0, done}, 32'd0);
        chk("flush result", result, last_result);
        seen = 1'b0;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            if (done || busy) seen = 1'b1;
        end
        chk("flush no done", {31'd0, seen}, 32'd0);

        // Reset at cycle 15 of a DIV
        @(negedge clk);
        start = 1'b1; op = 3'd4; srcop1 = 32'd1000; srcop2 = 32'd7;
        @(negedge clk);
        start = 1'b0;
        for (int c = 1; c < 15; c++) @(negedge clk);
        rst = 1'b0;
        #1;
        chk("rst busy", {31'd0, busy}, 32'd0);
        chk("rst done", {31'd0, done}, 32'd0);
        chk("rst result", result, 32'd0);
        last_result = '0;
        @(negedge clk);
        rst = 1'b1;
        seen = 1'b0;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            if (done || busy) seen = 1'b1;
        end
        chk("rst no done", {31'd0, seen}, 32'd0);

        // Random operations with noise on start while busy
        for (int i = 0; i < 40; i++) begin
            run_op(3'($urandom_range(0, 7)), pick_operand(), pick_operand(), 1'b1);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/ex_muldiv_ctrl.md
EX_MULDIV_CTRL -- requirements
Module: ex_muldiv_ctrl

Interface
REQ-001 SHALL provide: clk  input  1  system clock, all state updates on rising edge.
REQ-002 SHALL provide: rst  input  1  reset, asynchronous, active-low.
REQ-003 SHALL provide: start  input  1  request a new operation, sampled only in IDLE.
REQ-004 SHALL provide: op  input  3  RV32M funct3: 0 MUL, 1 MULH, 2 MULHSU, 3 MULHU, 4 DIV, 5 DIVU, 6 REM, 7 REMU.
REQ-005 SHALL provide: srcop1  input  32  rs1 operand (multiplicand/dividend).
REQ-006 SHALL provide: srcop2  input  32  rs2 operand (multiplier/divisor).
REQ-007 SHALL provide: flush  input  1  abort the in-flight operation.
REQ-008 SHALL provide: busy  output  1  operation in progress, used as pipeline stall.
REQ-009 SHALL provide: done  output  1  one-cycle pulse, result valid.
REQ-010 SHALL provide: result  output  32  final value, held until the next done.

Function
REQ-011 SHALL implement FSM states IDLE, CALC, FIX, DONE; encoding from the shared package.
REQ-012 IDLE->CALC when start=1; operands and op latched in that cycle (cycle 0); busy=1 from cycle 1.
REQ-013 CALC SHALL run exactly 32 iterations: shift-add for multiply (64-bit product), restoring shift-subtract for divide, using 5-bit counter 31 down to 0.
REQ-014 CALC->FIX when counter reaches 0; FIX applies sign correction (two's complement of magnitude result for signed ops) and selects high/low word or quotient/remainder.
REQ-015 FIX->DONE; done=1 and result updated in DONE (cycle 34); DONE->IDLE next cycle, busy=0 in DONE.
REQ-016 Signed ops SHALL operate on magnitudes; MULHSU treats only srcop1 as signed; REM sign follows dividend; DIV sign is XOR of operand signs.
REQ-017 Divide by zero SHALL skip CALC: quotient 32'hFFFFFFFF, remainder = srcop1, done at cycle 2.
REQ-018 Signed overflow (srcop1=32'h80000000, srcop2=32'hFFFFFFFF, DIV/REM) SHALL skip CALC: quotient 32'h80000000, remainder 0, done at cycle 2.
REQ-019 start while busy=1 or in DONE SHALL be ignored, no queueing.
REQ-020 flush=1 in any state SHALL return FSM to IDLE next cycle, suppress done, leave result unchanged; flush has priority over start in the same cycle.

Reset
REQ-021 rst=0 SHALL immediately force IDLE, busy=0, done=0, result=0, counter=0, internal accumulators=0.
REQ-022 Reset mid-operation SHALL discard the operation; no done after release.

Configuration
REQ-023 Macro MULDIV_EARLY_OUT_EN defined: multiply with srcop1=0 or srcop2=0 SHALL skip CALC, result 0, done at cycle 2.
REQ-024 Macro undefined: all non-exceptional operations SHALL take fixed latency, done at cycle 34.

Structure
REQ-025 Shared package/defines file SHALL hold op encodings, FSM state encodings, XLEN=32 and iteration count.
REQ-026 One sub-module muldiv_addsub (33-bit add/subtract with carry-out) SHALL be instantiated for the iteration step.

Verification
REQ-027 MUL 7 x 6: start cycle 0 -> done cycle 34, result 42, busy high cycles 1-33.
REQ-028 DIV -20 / 3 -> result 32'hFFFFFFFA (-6); REM same operands -> 32'hFFFFFFFE (-2).
REQ-029 DIVU 100 / 0 -> done cycle 2, result 32'hFFFFFFFF; REMU 100 / 0 -> result 100.
REQ-030 MULH 32'h80000000 x 32'h80000000 -> result 32'h40000000; MULHU 32'hFFFFFFFF x 2 -> result 1.
REQ-031 flush at cycle 10 of MUL, start asserted same cycle -> IDLE cycle 11, no done, result unchanged, start ignored.
REQ-032 rst low at cycle 15 of DIV -> busy=0 immediately, no done after release; with MULDIV_EARLY_OUT_EN, MUL 0 x 5 -> done cycle 2, result 0.
